wb_retire_unit: RTL and testbench

//  Writeback/retire stage consuming the MEM/WB pipeline register outputs. Selects and extends RF

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/wb_load_ext.sv | 43 ++++
 rtl/wb_retire_unit.sv | 181 ++++++++++++++++++
 tb/tb_wb_retire_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Encodings shared by the pipeline stages: writeback data select (RWSrc),
//   load format (OPSrc), PC source (PCSrc) and the halt drain FSM states.
//   FSM states are plain localparam vectors so older pipeline files that
//   compare against raw codes keep working.
package pipeline_pkg;

  // Writeback data select
  localparam logic [1:0] RW_ALU  = 2'b00;
  localparam logic [1:0] RW_LOAD = 2'b01;
  localparam logic [1:0] RW_PC4  = 2'b10;
  localparam logic [1:0] RW_COND = 2'b11;

  // Load format
  localparam logic [1:0] OP_WORD  = 2'b00;
  localparam logic [1:0] OP_HALF  = 2'b01;
  localparam logic [1:0] OP_BYTE  = 2'b10;
  localparam logic [1:0] OP_BYTEU = 2'b11;

  // PC source of the retiring entry
  localparam logic [1:0] PC_NONE   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RSVD   = 2'b11;

  // Halt drain FSM
  localparam logic [1:0] ST_RUN    = 2'b00;
  localparam logic [1:0] ST_DRAIN  = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

endpackage

// File: rtl/wb_load_ext.sv
// wb_load_ext
//   Purely combinational load aligner/extender.
//   Ports:
//     op_src  in  2   load format (word / half signed / byte signed / byte unsigned)
//     addr_lo in  2   low address bits selecting the byte or half lane
//     word    in  32  raw word read from data memory
//     data    out 32  aligned and extended load result
//   Half loads use addr_lo[1] only; word loads ignore addr_lo entirely.
module wb_load_ext
  import pipeline_pkg::*;
(
  input  logic [1:0]  op_src,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    half_v = addr_lo[1] ? word[31:16] : word[15:0];
    byte_v = word[7:0];
    case (addr_lo)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase

    data = word;
    case (op_src)
      OP_WORD:  data = word;
      OP_HALF:  data = {{16{half_v[15]}}, half_v};
      OP_BYTE:  data = {{24{byte_v[7]}}, byte_v};
      OP_BYTEU: data = {24'd0, byte_v};
      default:  data = word;
    endcase
  end

endmodule

// File: rtl/wb_retire_unit.sv
// wb_retire_unit
//   Writeback / retire stage fed by the MEM/WB pipeline register.
//   - Selects and extends RF write data, drives the RF write port.
//   - Drives the fetch redirect for taken branches and jumps.
//   - Counts retired instructions (NUM_INST, wraps).
//   - Holds a one-entry registered copy of the last RF write for ID forwarding.
//   - Runs the halt drain FSM: RUN -> DRAIN (DRAIN_CYCLES cycles) -> HALTED.
//   Ports:
//     CLK, RSTn          clock, synchronous active-low reset
//     STALL              entry in WB is not retired while high
//     RWSrc, OPSrc       write-data select, load format
//     PCSrc_MEMWB        redirect kind of the entry
//     RF_WE, NUM_CHECK   entry writes RF / counts as retired instruction
//     ALUOUT_MEMWB       ALU result, branch/jump target, load address
//     ADD_PC_MEMWB       PC+4 of the entry
//     D_MEM_DI_OUT       raw loaded word
//     WA_MEMWB           destination register
//     HALT               entry is a halt instruction
//     Branch_Cond_MEMWB  branch taken / compare result
//     RF_WE_OUT/RF_WA/RF_WD     RF write port (combinational)
//     PC_REDIR/PC_TARGET        fetch redirect (combinational)
//     FWD_VALID/FWD_WA/FWD_WD   registered last write
//     NUM_INST                  retired count
//     HALT_REQ / HALT_OUT       registered halt status
module wb_retire_unit
  import pipeline_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             STALL,
  input  logic [1:0]       RWSrc,
  input  logic [1:0]       OPSrc,
  input  logic [1:0]       PCSrc_MEMWB,
  input  logic             RF_WE,
  input  logic             NUM_CHECK,
  input  logic [31:0]      ALUOUT_MEMWB,
  input  logic [31:0]      ADD_PC_MEMWB,
  input  logic [31:0]      D_MEM_DI_OUT,
  input  logic [4:0]       WA_MEMWB,
  input  logic             HALT,
  input  logic             Branch_Cond_MEMWB,
  output logic             RF_WE_OUT,
  output logic [4:0]       RF_WA,
  output logic [31:0]      RF_WD,
  output logic             PC_REDIR,
  output logic [31:0]      PC_TARGET,
  output logic             FWD_VALID,
  output logic [4:0]       FWD_WA,
  output logic [31:0]      FWD_WD,
  output logic [CNT_W-1:0] NUM_INST,
  output logic             HALT_REQ,
  output logic             HALT_OUT
);

  localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

  logic [1:0]       state_q,     state_d;
  logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic             fwd_valid_q, fwd_valid_d;
  logic [4:0]       fwd_wa_q,    fwd_wa_d;
  logic [31:0]      fwd_wd_q,    fwd_wd_d;
  logic [CNT_W-1:0] num_inst_q,  num_inst_d;
  logic             halt_req_q,  halt_req_d;
  logic             halt_out_q,  halt_out_d;

  logic        retire;
  logic        wr_en;
  logic        redir_sel;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  // Only an unstalled entry in RUN retires; everything visible downstream
  // is gated by this.
  assign retire = ~STALL & (state_q == ST_RUN);

  wb_load_ext u_load_ext (
    .op_src  (OPSrc),
    .addr_lo (ALUOUT_MEMWB[1:0]),
    .word    (D_MEM_DI_OUT),
    .data    (load_data)
  );

  always_comb begin
    wb_data = ALUOUT_MEMWB;
    case (RWSrc)
      RW_ALU:  wb_data = ALUOUT_MEMWB;
      RW_LOAD: wb_data = load_data;
      RW_PC4:  wb_data = ADD_PC_MEMWB;
      RW_COND: wb_data = {31'd0, Branch_Cond_MEMWB};
      default: wb_data = ALUOUT_MEMWB;
    endcase
  end

  always_comb begin
    redir_sel = 1'b0;
    case (PCSrc_MEMWB)
      PC_NONE:   redir_sel = 1'b0;
      PC_BRANCH: redir_sel = Branch_Cond_MEMWB;
      PC_JUMP:   redir_sel = 1'b1;
      PC_RSVD:   redir_sel = 1'b0;
      default:   redir_sel = 1'b0;
    endcase
  end

  // A halt entry retires (and may count) but never writes x0..x31 or redirects.
  assign wr_en     = retire & ~HALT & RF_WE & (WA_MEMWB != 5'd0);
  assign RF_WE_OUT = wr_en;
  assign RF_WA     = retire ? WA_MEMWB : 5'd0;
  assign RF_WD     = retire ? wb_data : 32'd0;
  assign PC_REDIR  = retire & ~HALT & redir_sel;
  assign PC_TARGET = retire ? ALUOUT_MEMWB : 32'd0;

  always_comb begin
    // Forwarding copy: address/data hold when no write, valid drops.
    fwd_valid_d = wr_en;
    fwd_wa_d    = wr_en ? WA_MEMWB : fwd_wa_q;
    fwd_wd_d    = wr_en ? wb_data  : fwd_wd_q;

    num_inst_d  = (retire & NUM_CHECK) ? num_inst_q + CNT_W'(1) : num_inst_q;

    // Drain counter runs independently of STALL once in DRAIN.
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (retire & HALT) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == '0) state_d = ST_HALTED;
        else                   drain_cnt_d = drain_cnt_q - 1'b1;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase

    // Status flags are registered copies of the state being entered.
    halt_req_d = (state_d != ST_RUN);
    halt_out_d = (state_d == ST_HALTED);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  // NOTE: reset is synchronous (only sampled on the clock edge), matching
  // the rest of the pipeline.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      fwd_valid_q <= 1'b0;
      fwd_wa_q    <= 5'd0;
      fwd_wd_q    <= 32'd0;
      num_inst_q  <= '0;
      halt_req_q  <= 1'b0;
      halt_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_wa_q    <= fwd_wa_d;
      fwd_wd_q    <= fwd_wd_d;
      num_inst_q  <= num_inst_d;
      halt_req_q  <= halt_req_d;
      halt_out_q  <= halt_out_d;
    end
  end

  assign FWD_VALID = fwd_valid_q;
  assign FWD_WA    = fwd_wa_q;
  assign FWD_WD    = fwd_wd_q;
  assign NUM_INST  = num_inst_q;
  assign HALT_REQ  = halt_req_q;
  assign HALT_OUT  = halt_out_q;

endmodule

// File: tb/tb_wb_retire_unit.sv
// tb_wb_retire_unit
//   Directed plus randomized stimulus against a behavioural model. The model
//   tracks the cycle at which a halt retired instead of an FSM; a second DUT
//   with a 3-bit counter exercises counter wrap-around.
module tb_wb_retire_unit;

  localparam int DRAIN = 2;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        STALL;
  logic [1:0]  RWSrc, OPSrc, PCSrc_MEMWB;
  logic        RF_WE, NUM_CHECK, HALT, Branch_Cond_MEMWB;
  logic [31:0] ALUOUT_MEMWB, ADD_PC_MEMWB, D_MEM_DI_OUT;
  logic [4:0]  WA_MEMWB;

  logic        RF_WE_OUT, PC_REDIR, FWD_VALID, HALT_REQ, HALT_OUT;
  logic [4:0]  RF_WA, FWD_WA;
  logic [31:0] RF_WD, PC_TARGET, FWD_WD, NUM_INST;

  logic        rf_we_3, pc_redir_3, fwd_valid_3, halt_req_3, halt_out_3;
  logic [4:0]  rf_wa_3, fwd_wa_3;
  logic [31:0] rf_wd_3, pc_target_3, fwd_wd_3;
  logic [2:0]  num_inst_3;

  always #5 CLK = ~CLK;

  wb_retire_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) u_dut (
    .CLK(CLK), .RSTn(RSTn), .STALL(STALL), .RWSrc(RWSrc), .OPSrc(OPSrc),
    .PCSrc_MEMWB(PCSrc_MEMWB), .RF_WE(RF_WE), .NUM_CHECK(NUM_CHECK),
    .ALUOUT_MEMWB(ALUOUT_MEMWB), .ADD_PC_MEMWB(ADD_PC_MEMWB),
    .D_MEM_DI_OUT(D_MEM_DI_OUT), .WA_MEMWB(WA_MEMWB), .HALT(HALT),
    .Branch_Cond_MEMWB(Branch_Cond_MEMWB), .RF_WE_OUT(RF_WE_OUT), .RF_WA(RF_WA),
    .RF_WD(RF_WD), .PC_REDIR(PC_REDIR), .PC_TARGET(PC_TARGET),
    .FWD_VALID(FWD_VALID), .FWD_WA(FWD_WA), .FWD_WD(FWD_WD),
    .NUM_INST(NUM_INST), .HALT_REQ(HALT_REQ), .HALT_OUT(HALT_OUT)
  );

  wb_retire_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(3)) u_dut3 (
    .CLK(CLK), .RSTn(RSTn), .STALL(STALL), .RWSrc(RWSrc), .OPSrc(OPSrc),
    .PCSrc_MEMWB(PCSrc_MEMWB), .RF_WE(RF_WE), .NUM_CHECK(NUM_CHECK),
    .ALUOUT_MEMWB(ALUOUT_MEMWB), .ADD_PC_MEMWB(ADD_PC_MEMWB),
    .D_MEM_DI_OUT(D_MEM_DI_OUT), .WA_MEMWB(WA_MEMWB), .HALT(HALT),
    .Branch_Cond_MEMWB(Branch_Cond_MEMWB), .RF_WE_OUT(rf_we_3), .RF_WA(rf_wa_3),
    .RF_WD(rf_wd_3), .PC_REDIR(pc_redir_3), .PC_TARGET(pc_target_3),
    .FWD_VALID(fwd_valid_3), .FWD_WA(fwd_wa_3), .FWD_WD(fwd_wd_3),
    .NUM_INST(num_inst_3), .HALT_REQ(halt_req_3), .HALT_OUT(halt_out_3)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit          fwd_v_m;
  logic [4:0]  fwd_wa_m;
  logic [31:0] fwd_wd_m;
  logic [31:0] cnt_m;
  int          halt_at;   // cycle index at which a halt retired, -1 if none
  int          cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Expected write data from the instruction-set rules.
  function automatic logic [31:0] exp_data();
    logic [31:0] v;
    int unsigned sh;
    case (RWSrc)
      2'b00: return ALUOUT_MEMWB;
      2'b10: return ADD_PC_MEMWB;
      2'b11: return {31'd0, Branch_Cond_MEMWB};
      default: begin
        case (OPSrc)
          2'b00: return D_MEM_DI_OUT;
          2'b01: begin
            sh = ALUOUT_MEMWB[1] ? 16 : 0;
            v  = (D_MEM_DI_OUT >> sh) & 32'hFFFF;
            if (v >= 32'h8000) v = v + 32'hFFFF_0000;
            return v;
          end
          default: begin
            sh = 8 * ALUOUT_MEMWB[1:0];
            v  = (D_MEM_DI_OUT >> sh) & 32'hFF;
            if (OPSrc == 2'b10 && v >= 32'h80) v = v + 32'hFFFF_FF00;
            return v;
          end
        endcase
      end
    endcase
  endfunction

  // One clock cycle: called just after a falling edge with inputs applied.
  task automatic step();
    bit          ret, we, redir;
    logic [31:0] wd;
    #1;
    ret   = RSTn && !STALL && (halt_at < 0);
    we    = ret && !HALT && RF_WE && (WA_MEMWB != 5'd0);
    redir = ret && !HALT && ((PCSrc_MEMWB == 2'b01 && Branch_Cond_MEMWB) || PCSrc_MEMWB == 2'b10);
    wd    = exp_data();
    if (RSTn) begin
      check("rf_we", {31'd0, RF_WE_OUT}, {31'd0, we});
      check("rf_we_w3", {31'd0, rf_we_3}, {31'd0, we});
      check("pc_redir", {31'd0, PC_REDIR}, {31'd0, redir});
      if (we) begin
        check("rf_wa", {27'd0, RF_WA}, {27'd0, WA_MEMWB});
        check("rf_wd", RF_WD, wd);
      end
      if (redir) check("pc_target", PC_TARGET, ALUOUT_MEMWB);
    end
    @(posedge CLK);
    if (!RSTn) begin
      fwd_v_m  = 1'b0;
      fwd_wa_m = 5'd0;
      fwd_wd_m = 32'd0;
      cnt_m    = 32'd0;
      halt_at  = -1;
    end else begin
      fwd_v_m = we;
      if (we) begin
        fwd_wa_m = WA_MEMWB;
        fwd_wd_m = wd;
      end
      if (ret && NUM_CHECK) cnt_m = cnt_m + 32'd1;
      if (ret && HALT) halt_at = cyc;
    end
    cyc++;
    #1;
    check("fwd_valid", {31'd0, FWD_VALID}, {31'd0, fwd_v_m});
    check("fwd_wa", {27'd0, FWD_WA}, {27'd0, fwd_wa_m});
    check("fwd_wd", FWD_WD, fwd_wd_m);
    check("num_inst", NUM_INST, cnt_m);
    check("num_inst_w3", {29'd0, num_inst_3}, cnt_m & 32'h7);
    check("halt_req", {31'd0, HALT_REQ}, {31'd0, halt_at >= 0});
    check("halt_out", {31'd0, HALT_OUT}, {31'd0, halt_at >= 0 && cyc >= halt_at + 1 + DRAIN});
    check("halt_out_w3", {31'd0, halt_out_3}, {31'd0, halt_at >= 0 && cyc >= halt_at + 1 + DRAIN});
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    STALL = 0; RWSrc = 2'b00; OPSrc = 2'b00; PCSrc_MEMWB = 2'b00;
    RF_WE = 0; NUM_CHECK = 0; HALT = 0; Branch_Cond_MEMWB = 0;
    ALUOUT_MEMWB = 0; ADD_PC_MEMWB = 0; D_MEM_DI_OUT = 0; WA_MEMWB = 0;
  endtask

  task automatic do_reset();
    RSTn = 0;
    step();
    RSTn = 1;
  endtask

  logic [31:0] load_exp [4];
  logic [1:0]  load_op  [4];

  initial begin
    fwd_v_m = 0; fwd_wa_m = 0; fwd_wd_m = 0; cnt_m = 0; halt_at = -1; cyc = 0;
    idle_inputs();
    RSTn = 0;
    @(negedge CLK);
    step();
    step();
    RSTn = 1;
    check("reset_num_inst", NUM_INST, 32'd0);
    check("reset_halt_req", {31'd0, HALT_REQ}, 32'd0);
    check("reset_fwd_valid", {31'd0, FWD_VALID}, 32'd0);

    // Load extension from lane 2 of 0x80FF7F01
    load_op[0] = 2'b10; load_exp[0] = 32'hFFFF_FFFF;
    load_op[1] = 2'b11; load_exp[1] = 32'h0000_00FF;
    load_op[2] = 2'b01; load_exp[2] = 32'hFFFF_80FF;
    load_op[3] = 2'b00; load_exp[3] = 32'h80FF_7F01;
    RWSrc = 2'b01; D_MEM_DI_OUT = 32'h80FF_7F01; ALUOUT_MEMWB = 32'h0000_1002;
    RF_WE = 1; WA_MEMWB = 5'd7;
    for (int i = 0; i < 4; i++) begin
      OPSrc = load_op[i];
      #1 check("load_ext", RF_WD, load_exp[i]);
      step();
    end

    // Write to x0 is dropped; x3 is forwarded
    RWSrc = 2'b00; OPSrc = 2'b00; ALUOUT_MEMWB = 32'd5; WA_MEMWB = 5'd0;
    #1 check("x0_we", {31'd0, RF_WE_OUT}, 32'd0);
    step();
    check("x0_fwd_valid", {31'd0, FWD_VALID}, 32'd0);
    WA_MEMWB = 5'd3;
    step();
    check("fwd_x3_valid", {31'd0, FWD_VALID}, 32'd1);
    check("fwd_x3_wa", {27'd0, FWD_WA}, 32'd3);
    check("fwd_x3_wd", FWD_WD, 32'd5);
    RF_WE = 0;

    // Branch redirect
    PCSrc_MEMWB = 2'b01; Branch_Cond_MEMWB = 0;
    #1 check("br_not_taken", {31'd0, PC_REDIR}, 32'd0);
    step();
    Branch_Cond_MEMWB = 1; ALUOUT_MEMWB = 32'h100;
    #1 check("br_taken", {31'd0, PC_REDIR}, 32'd1);
    check("br_target", PC_TARGET, 32'h100);
    step();
    STALL = 1;
    #1 check("br_stalled", {31'd0, PC_REDIR}, 32'd0);
    step();
    idle_inputs();

    // Counting with stalls, then wrap of the 3-bit instance
    do_reset();
    NUM_CHECK = 1;
    for (int i = 0; i < 10; i++) begin
      STALL = (i == 2 || i == 5 || i == 8);
      step();
    end
    STALL = 0;
    check("count_7", NUM_INST, 32'd7);
    step();
    check("wrap_w3", {29'd0, num_inst_3}, 32'd0);
    check("count_8", NUM_INST, 32'd8);

    // Randomized run without halts
    for (int i = 0; i < 400; i++) begin
      STALL             = ($urandom_range(0, 3) == 0);
      RWSrc             = 2'($urandom);
      OPSrc             = 2'($urandom);
      PCSrc_MEMWB       = 2'($urandom);
      RF_WE             = 1'($urandom);
      NUM_CHECK         = 1'($urandom);
      Branch_Cond_MEMWB = 1'($urandom);
      ALUOUT_MEMWB      = $urandom;
      ADD_PC_MEMWB      = $urandom;
      D_MEM_DI_OUT      = $urandom;
      WA_MEMWB          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step();
    end
    idle_inputs();

    // Halt held off by stall, then drain; writes suppressed; reset in DRAIN
    HALT = 1; STALL = 1; NUM_CHECK = 1;
    for (int i = 0; i < 3; i++) step();
    check("halt_stalled", {31'd0, HALT_REQ}, 32'd0);
    STALL = 0;
    step();
    check("halt_req_set", {31'd0, HALT_REQ}, 32'd1);
    HALT = 0; RF_WE = 1; WA_MEMWB = 5'd9; ALUOUT_MEMWB = 32'h55;
    PCSrc_MEMWB = 2'b10;
    #1 check("drain_no_write", {31'd0, RF_WE_OUT}, 32'd0);
    check("drain_no_redir", {31'd0, PC_REDIR}, 32'd0);
    step();
    do_reset();
    check("rst_drain_halt_req", {31'd0, HALT_REQ}, 32'd0);

    // Full drain to HALTED, then reset out of HALTED
    HALT = 1; RF_WE = 0; PCSrc_MEMWB = 2'b00;
    step();
    HALT = 0; RF_WE = 1;
    step();
    check("drain_halt_out0", {31'd0, HALT_OUT}, 32'd0);
    step();
    check("halted_halt_out", {31'd0, HALT_OUT}, 32'd1);
    HALT = 1;
    for (int i = 0; i < 3; i++) step();
    do_reset();
    HALT = 0;
    step();
    check("run_after_reset", {31'd0, FWD_VALID}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
